uart_loader: RTL and testbench
==============================

// Module: uart_loader
// PURPOSE
//   Serial boot/program loader that consumes bytes from the UART receive FIFO.
//   Parses framed write packets and writes the payload words into memory through a simple write port.
//   Returns a one-byte ACK/NAK to the UART transmit FIFO for each packet.
//   Holds busy high while a packet is being processed, so the top level can stall the CPU during loading.
// PARAMETERS
//   ADDR_W   32         memory address width; a multiple of 8
//   DATA_W   32         memory word width; a multiple of 8; WB = DATA_W/8 bytes per word
//   SYNC     8'hA5      packet start byte
//   ACK      8'h06      response byte when the checksum matches
//   NAK      8'h15      response byte when the checksum mismatches
//   TIMEOUT  1000000    maximum idle clk cycles between bytes inside a packet
// PORTS
//   clk        in   1       system clock
//   rst_       in   1       asynchronous active-low reset
//   rx_empty   in   1       RX FIFO empty
//   rx_re      out  1       RX FIFO read strobe; data appears on rx_data the next cycle
//   rx_data    in   8       RX FIFO read data
//   tx_full    in   1       TX FIFO full
//   tx_we      out  1       TX FIFO write strobe, one cycle
//   tx_data    out  8       TX FIFO write data
//   mem_we     out  1       memory write request
//   mem_addr   out  ADDR_W  byte address of the word
//   mem_wdata  out  DATA_W  write data
//   mem_stall  in   1       memory not ready; a transfer completes on mem_we & !mem_stall
//   busy       out  1       high from the SYNC byte until the response is issued or the packet aborts
//   done       out  1       one-cycle pulse when ACK is written
//   err        out  1       one-cycle pulse on a NAK write or on a timeout abort
// BEHAVIOUR
//   Reset: every output is 0, the FSM is in IDLE, and all counters and the checksum are cleared.
//   Packet format, all fields little-endian:
//     SYNC, ADDR (ADDR_W/8 B), LEN (2 B, word count), LEN*WB data bytes, CHK (1 B).
//   CHK is the XOR of all bytes from ADDR through the last data byte; SYNC is excluded.
//   Byte intake:
//     - rx_re is asserted only when !rx_empty, no byte is pending, and the state accepts bytes.
//     - The byte is consumed on the cycle after rx_re, so at most one read is in flight.
//     - The resulting throughput is at most one byte per 2 cycles.
//   FSM states: IDLE, ADDR, LEN, DATA, WRITE, CHK, RESP.
//     IDLE: discard every byte that is not SYNC. On SYNC: busy=1, clear the checksum, go to ADDR.
//     ADDR: shift in ADDR_W/8 bytes, then go to LEN.
//     LEN:  shift in 2 bytes. If LEN==0 go to CHK, otherwise go to DATA.
//     DATA: assemble WB bytes, then go to WRITE. No rx_re is issued in WRITE.
//     WRITE:
//       - mem_we=1 with mem_addr/mem_wdata held stable while mem_stall is high.
//       - On completion: mem_we=0, mem_addr += WB (wraps mod 2^ADDR_W), remaining words -1.
//       - Then go to CHK if no words remain, otherwise back to DATA.
//     CHK: read 1 byte. If it equals the running XOR, tx_data=ACK, otherwise tx_data=NAK. Go to RESP.
//     RESP:
//       - Wait while tx_full is high.
//       - Then for one cycle: tx_we=1 and busy=0, plus done=1 (ACK) or err=1 (NAK). Go to IDLE.
//   Memory writes are not rolled back on a NAK. The host is responsible for retrying.
//   Timeout:
//     - A counter is cleared on each consumed byte and runs only in ADDR, LEN, DATA and CHK.
//     - When it reaches TIMEOUT: go to IDLE, busy=0, err pulses for one cycle, no response is sent.
//     - A partial word is dropped.
//   A SYNC byte inside a packet is treated as data; there is no resynchronisation until IDLE.
//   An async reset mid-packet aborts immediately. Any in-flight mem_we or tx_we drops at once.
// TESTING
//   1 A5, 00 01 00 00, 02 00, 44 33 22 11, EF BE AD DE, 65
//       -> writes 0x11223344@0x100 and 0xDEADBEEF@0x104; tx 06; done pulse; busy low.
//   2 Same as 1 but CHK=0x66 -> same two writes; tx 15; err pulse; no done.
//   3 Bytes 00 FF 5A before packet 1 -> ignored; busy stays 0 until A5; result as 1.
//   4 LEN=0 packet A5, 10 00 00 00, 00 00, 10 -> no mem_we; tx 06.
//   5 mem_stall high 5 cycles on the first write; tx_full high 3 cycles in RESP
//       -> mem_we and data stable throughout; exactly two writes; exactly one tx_we.
//   6 Stop mid-DATA for TIMEOUT cycles (bench uses TIMEOUT=50)
//       -> err pulse, no tx_we, IDLE; a following valid packet is ACKed.
//   7 rst_ low mid-DATA -> all outputs 0 asynchronously; a subsequent packet is ACKed.

Source files
------------

// File: rtl/uart_loader.sv
// uart_loader: serial boot loader that frames bytes from a UART RX FIFO into
// memory write transactions and answers each packet with an ACK/NAK byte.
// Packet: SYNC, ADDR (LE), LEN (2 B LE, words), LEN*WB data bytes, CHK (XOR).
module uart_loader #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter logic [7:0]  ACK     = 8'h06,
  parameter logic [7:0]  NAK     = 8'h15,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              rx_empty,
  output logic              rx_re,
  input  logic [7:0]        rx_data,
  input  logic              tx_full,
  output logic              tx_we,
  output logic [7:0]        tx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned AB    = ADDR_W / 8;
  localparam int unsigned WB    = DATA_W / 8;
  localparam int unsigned MAXB  = (AB > WB) ? AB : WB;
  localparam int unsigned MAXB2 = (MAXB > 2) ? MAXB : 2;
  localparam int unsigned CNT_W = $clog2(MAXB2);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_RESP
  } state_t;

  state_t             state_q;
  logic               rx_re_q;
  logic               vld_q;      // rx_data holds the byte requested last cycle
  logic [CNT_W-1:0]   bcnt_q;     // byte index inside the current field
  logic [15:0]        wcnt_q;     // LEN while parsing, then words remaining
  logic [7:0]         chk_q;
  logic               ok_q;       // checksum matched
  logic [TMO_W-1:0]   tmo_q;
  logic               tx_we_q;
  logic [7:0]         tx_data_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q; // address shift register, then write pointer
  logic [DATA_W-1:0]  mem_wdata_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic rx_ok;
  logic tmo_run;
  logic tmo_hit;
  logic [15:0] len_full;

  assign rx_ok    = state_q inside {S_IDLE, S_ADDR, S_LEN, S_DATA, S_CHK};
  assign tmo_run  = state_q inside {S_ADDR, S_LEN, S_DATA, S_CHK};
  assign tmo_hit  = tmo_run && !vld_q && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign len_full = {rx_data, wcnt_q[15:8]};

  // Packet FSM: byte intake, field assembly, memory writes, response and timeout.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= S_IDLE;
      rx_re_q     <= 1'b0;
      vld_q       <= 1'b0;
      bcnt_q      <= '0;
      wcnt_q      <= '0;
      chk_q       <= '0;
      ok_q        <= 1'b0;
      tmo_q       <= '0;
      tx_we_q     <= 1'b0;
      tx_data_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      tx_we_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      // Only one read in flight: no new request while one is issued or pending.
      vld_q   <= rx_re_q;
      rx_re_q <= rx_ok && !rx_re_q && !vld_q && !rx_empty;

      if (vld_q || state_q == S_IDLE) begin
        tmo_q <= '0;
      end else if (tmo_run) begin
        tmo_q <= tmo_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (vld_q && rx_data == SYNC) begin
            busy_q  <= 1'b1;
            chk_q   <= '0;
            bcnt_q  <= '0;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (vld_q) begin
            chk_q      <= chk_q ^ rx_data;
            mem_addr_q <= ADDR_W'({rx_data, mem_addr_q} >> 8);
            if (bcnt_q == CNT_W'(AB - 1)) begin
              bcnt_q  <= '0;
              state_q <= S_LEN;
            end else begin
              bcnt_q <= bcnt_q + 1'b1;
            end
          end
        end
        S_LEN: begin
          if (vld_q) begin
            chk_q  <= chk_q ^ rx_data;
            wcnt_q <= len_full;
            if (bcnt_q == CNT_W'(1)) begin
              bcnt_q  <= '0;
              state_q <= (len_full == 16'd0) ? S_CHK : S_DATA;
            end else begin
              bcnt_q <= bcnt_q + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (vld_q) begin
            chk_q       <= chk_q ^ rx_data;
            mem_wdata_q <= DATA_W'({rx_data, mem_wdata_q} >> 8);
            if (bcnt_q == CNT_W'(WB - 1)) begin
              bcnt_q   <= '0;
              mem_we_q <= 1'b1;
              state_q  <= S_WRITE;
            end else begin
              bcnt_q <= bcnt_q + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (!mem_stall) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= mem_addr_q + ADDR_W'(WB);
            wcnt_q     <= wcnt_q - 1'b1;
            state_q    <= (wcnt_q == 16'd1) ? S_CHK : S_DATA;
          end
        end
        S_CHK: begin
          if (vld_q) begin
            ok_q      <= (rx_data == chk_q);
            tx_data_q <= (rx_data == chk_q) ? ACK : NAK;
            state_q   <= S_RESP;
          end
        end
        S_RESP: begin
          if (!tx_full) begin
            tx_we_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= ok_q;
            err_q   <= !ok_q;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // Abort overrides the field handling above; no byte is consumed this cycle.
      if (tmo_hit) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        err_q   <= 1'b1;
        bcnt_q  <= '0;
        tmo_q   <= '0;
      end
    end
  end

  assign rx_re     = rx_re_q;
  assign tx_we     = tx_we_q;
  assign tx_data   = tx_data_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader with an RX FIFO model and write/response scoreboard.
module tb_uart_loader;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 50;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_;
  logic          rx_empty = 1'b1;
  logic          rx_re;
  logic [7:0]    rx_data = 8'h00;
  logic          tx_full;
  logic          tx_we;
  logic [7:0]    tx_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_stall;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  uart_loader #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .SYNC   (8'hA5),
    .ACK    (8'h06),
    .NAK    (8'h15),
    .TIMEOUT(TMO)
  ) dut (
    .clk      (clk),
    .rst_     (rst_),
    .rx_empty (rx_empty),
    .rx_re    (rx_re),
    .rx_data  (rx_data),
    .tx_full  (tx_full),
    .tx_we    (tx_we),
    .tx_data  (tx_data),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_stall(mem_stall),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  logic [7:0]  rxq[$];
  logic [31:0] wq[$];
  wr_t         exp_wr[$];
  wr_t         act_wr[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  act_tx[$];

  int tests = 0;
  int fails = 0;
  int ndone = 0, nerr = 0, ntx = 0, nwr = 0;
  int exp_done = 0, exp_err = 0, tot_tx = 0;
  int proto_err = 0, stab_err = 0;
  logic prev_st = 1'b0;
  wr_t  prev_wr;

  // RX FIFO model: pops on rx_re, data valid the following cycle.
  always @(posedge clk) begin
    if (rx_re && rxq.size() > 0) rx_data <= rxq.pop_front();
    rx_empty <= (rxq.size() == 0);
  end

  // Output monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_) begin
      prev_st = 1'b0;
    end else begin
      if (rx_re && rxq.size() == 0) proto_err++;
      if (prev_st && (!mem_we || {mem_addr, mem_wdata} != prev_wr)) stab_err++;
      prev_st = mem_we && mem_stall;
      prev_wr = {mem_addr, mem_wdata};
      if (mem_we && !mem_stall) begin
        act_wr.push_back({mem_addr, mem_wdata});
        nwr++;
      end
      if (tx_we) begin
        act_tx.push_back(tx_data);
        ntx++;
      end
      if (done) ndone++;
      if (err) nerr++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_bytes(input logic [7:0] b);
    rxq.push_back(b);
  endtask

  // Frames the words in wq at addr; flip corrupts the checksum when nonzero.
  task automatic send_pkt(input logic [31:0] addr, input logic [7:0] flip);
    logic [7:0]  x;
    logic [7:0]  b;
    logic [15:0] len;
    logic [31:0] w;
    x = 8'h00;
    rxq.push_back(8'hA5);
    for (int i = 0; i < 4; i++) begin
      b = addr[8*i +: 8];
      rxq.push_back(b);
      x ^= b;
    end
    len = 16'(wq.size());
    for (int i = 0; i < 2; i++) begin
      b = len[8*i +: 8];
      rxq.push_back(b);
      x ^= b;
    end
    for (int k = 0; k < wq.size(); k++) begin
      w = wq[k];
      for (int i = 0; i < 4; i++) begin
        b = w[8*i +: 8];
        rxq.push_back(b);
        x ^= b;
      end
      exp_wr.push_back({addr + 32'(4 * k), w});
    end
    rxq.push_back(x ^ flip);
    tot_tx++;
    if (flip == 8'h00) begin
      exp_tx.push_back(8'h06);
      exp_done++;
    end else begin
      exp_tx.push_back(8'h15);
      exp_err++;
    end
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 3000 && ntx < tot_tx; i++) @(posedge clk);
    cyc(3);
  endtask

  task automatic drain(input string tag);
    wr_t        e;
    wr_t        a;
    logic [7:0] et;
    logic [7:0] at;
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      if (act_wr.size() > 0) a = act_wr.pop_front();
      else a = '1;
      chk({tag, "_write"}, a, e);
    end
    chk({tag, "_extra_writes"}, 64'(act_wr.size()), 64'd0);
    while (exp_tx.size() > 0) begin
      et = exp_tx.pop_front();
      if (act_tx.size() > 0) at = act_tx.pop_front();
      else at = 8'hXX;
      chk({tag, "_tx"}, 64'(at), 64'(et));
    end
    chk({tag, "_extra_tx"}, 64'(act_tx.size()), 64'd0);
    chk({tag, "_done_cnt"}, 64'(ndone), 64'(exp_done));
    chk({tag, "_err_cnt"}, 64'(nerr), 64'(exp_err));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    act_wr.delete();
    act_tx.delete();
  endtask

  initial begin
    int base;
    rst_      = 1'b0;
    mem_stall = 1'b0;
    tx_full   = 1'b0;
    cyc(3);
    chk("reset_ctrl", 64'({rx_re, tx_we, tx_data, mem_we, busy, done, err}), 64'd0);
    chk("reset_addr", 64'(mem_addr), 64'd0);
    chk("reset_wdata", 64'(mem_wdata), 64'd0);
    rst_ = 1'b1;
    cyc(2);

    // Basic two-word packet, good checksum.
    wq = '{32'h11223344, 32'hDEADBEEF};
    send_pkt(32'h0000_0100, 8'h00);
    wait_resp();
    drain("t1");

    // Same packet, checksum 0x66 instead of 0x65.
    send_pkt(32'h0000_0100, 8'h03);
    wait_resp();
    drain("t2");

    // Junk before SYNC is discarded without raising busy.
    push_bytes(8'h00);
    push_bytes(8'hFF);
    push_bytes(8'h5A);
    cyc(15);
    chk("t3_junk_busy", 64'(busy), 64'd0);
    chk("t3_junk_drained", 64'(rxq.size()), 64'd0);
    send_pkt(32'h0000_0100, 8'h00);
    wait_resp();
    drain("t3");

    // Zero-length packet.
    wq = {};
    send_pkt(32'h0000_0010, 8'h00);
    wait_resp();
    drain("t4");

    // Stalled first write and full TX FIFO.
    mem_stall = 1'b1;
    tx_full   = 1'b1;
    base      = ntx;
    wq = '{32'hCAFEF00D, 32'h01020304};
    send_pkt(32'h0000_2000, 8'h00);
    for (int i = 0; i < 500 && !mem_we; i++) cyc(1);
    chk("t5_we_seen", 64'(mem_we), 64'd1);
    cyc(5);
    chk("t5_no_write_stalled", 64'(nwr - (nwr - act_wr.size())), 64'd0);
    mem_stall = 1'b0;
    for (int i = 0; i < 500 && act_wr.size() < 2; i++) cyc(1);
    cyc(20);
    chk("t5_no_tx_while_full", 64'(ntx - base), 64'd0);
    chk("t5_busy_while_full", 64'(busy), 64'd1);
    tx_full = 1'b0;
    wait_resp();
    chk("t5_one_tx", 64'(ntx - base), 64'd1);
    chk("t5_stable", 64'(stab_err), 64'd0);
    drain("t5");

    // Timeout mid-DATA: two of four data bytes then silence.
    base = ntx;
    push_bytes(8'hA5);
    push_bytes(8'h00); push_bytes(8'h05); push_bytes(8'h00); push_bytes(8'h00);
    push_bytes(8'h01); push_bytes(8'h00);
    push_bytes(8'hAA); push_bytes(8'hBB);
    cyc(35);
    chk("t6_busy_mid", 64'(busy), 64'd1);
    exp_err++;
    for (int i = 0; i < 400 && nerr < exp_err; i++) cyc(1);
    cyc(3);
    chk("t6_no_tx", 64'(ntx - base), 64'd0);
    drain("t6_abort");
    wq = '{32'h55667788};
    send_pkt(32'h0000_0300, 8'h00);
    wait_resp();
    drain("t6");

    // Asynchronous reset mid-DATA.
    push_bytes(8'hA5);
    push_bytes(8'h00); push_bytes(8'h04); push_bytes(8'h00); push_bytes(8'h00);
    push_bytes(8'h01); push_bytes(8'h00);
    push_bytes(8'h12); push_bytes(8'h34);
    cyc(32);
    chk("t7_busy_mid", 64'(busy), 64'd1);
    #2;
    rst_ = 1'b0;
    #1;
    chk("t7_async_ctrl", 64'({rx_re, tx_we, tx_data, mem_we, busy, done, err}), 64'd0);
    chk("t7_async_addr", 64'(mem_addr), 64'd0);
    rxq.delete();
    cyc(3);
    rst_ = 1'b1;
    cyc(3);
    wq = '{32'h0BADF00D, 32'h600DCAFE};
    send_pkt(32'h0000_0500, 8'h00);
    wait_resp();
    drain("t7");

    chk("rx_protocol", 64'(proto_err), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
